// File: rtl/rate_counter_display.sv
// rate_counter_display: rate-selectable WIDTH-bit counter with one active-low hex digit per nibble.
// Optional feature macro RC_UPDOWN_EN adds the `up` port for down counting.
module rate_counter_display #(
   parameter int WIDTH   = 4,
   parameter int PERIOD1 = 50_000_000,
   parameter int PERIOD2 = 25_000_000,
   parameter int PERIOD3 = 12_500_000
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     enable,
   input  logic [1:0]               sel,
   input  logic                     load,
   input  logic [WIDTH-1:0]         load_value,
`ifdef RC_UPDOWN_EN
   input  logic                     up,
`endif
   output logic [WIDTH-1:0]         count,
   output logic                     tick,
   output logic                     wrap,
   output logic [7*(WIDTH/4)-1:0]   hex
);
   localparam int MAX12 = PERIOD1 > PERIOD2 ? PERIOD1 : PERIOD2;
   localparam int MAXP  = MAX12 > PERIOD3 ? MAX12 : PERIOD3;
   localparam int DW    = $clog2(MAXP);
   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   logic [DW-1:0] div;
   logic [DW-1:0] reload;
   logic [1:0]    sel_q;
   logic          step;
   logic          down;
   logic          at_end;
   assign reload = sel == 2'b01 ? DW'(PERIOD1 - 1) :
                   sel == 2'b10 ? DW'(PERIOD2 - 1) :
                   sel == 2'b11 ? DW'(PERIOD3 - 1) : '0;
`ifdef RC_UPDOWN_EN
   assign down = ~up;
`else
   assign down = 1'b0;
`endif
   // a rate change restarts the divider instead of producing a short or long period
   assign step   = enable & (sel == sel_q) & (sel == 2'b00 | div == '0);
   assign at_end = down ? count == '0 : &count;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         sel_q <= sel;
         div   <= reload;
         count <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         sel_q <= sel;
         div   <= (load | step | sel != sel_q) ? reload : enable ? div - DW'(1) : div;
         count <= load ? load_value : step ? (down ? count - WIDTH'(1) : count + WIDTH'(1)) : count;
         tick  <= step & ~load;
         wrap  <= step & ~load & at_end;
      end
   for (genvar k = 0; k < WIDTH / 4; k++) begin : g_hex
      assign hex[7*k +: 7] = GLYPH[count[4*k +: 4]];
   end
endmodule

// File: tb/tb_rate_counter_display.sv
// tb_rate_counter_display: directed vector table plus hand sequences for reset and freeze corners.
module tb_rate_counter_display;
   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  sel = 2'b00;
   logic        load = 1'b0;
   logic [7:0]  load_value = 8'h00;
   logic        up = 1'b1;
   logic [7:0]  count;
   logic        tick;
   logic        wrap;
   logic [13:0] hex;
   int applied = 0;
   int miscompares = 0;

   typedef struct {
      logic       en;
      logic [1:0] sel;
      logic       ld;
      logic [7:0] lv;
      logic       up;
      logic [7:0] c;
      logic       t;
      logic       w;
   } vec_t;
   vec_t vecs[$];

   rate_counter_display #(.WIDTH(8), .PERIOD1(4), .PERIOD2(3), .PERIOD3(2)) dut (
      .clock(clock),
      .resetn(resetn),
      .enable(enable),
      .sel(sel),
      .load(load),
      .load_value(load_value),
`ifdef RC_UPDOWN_EN
      .up(up),
`endif
      .count(count),
      .tick(tick),
      .wrap(wrap),
      .hex(hex)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   task automatic check(input string name, input logic [7:0] c, input logic t, input logic w);
      logic [13:0] h;
      h = {glyph(c[7:4]), glyph(c[3:0])};
      applied++;
      if (count !== c || tick !== t || wrap !== w || hex !== h) begin
         miscompares++;
         $display("FAIL %s: got count=%h tick=%b wrap=%b hex=%h, want count=%h tick=%b wrap=%b hex=%h",
                  name, count, tick, wrap, hex, c, t, w, h);
      end
   endtask

   task automatic add(input logic en, input logic [1:0] s, input logic ld, input logic [7:0] lv,
                      input logic u, input logic [7:0] c, input logic t, input logic w);
      vecs.push_back('{en, s, ld, lv, u, c, t, w});
   endtask

   initial begin
      // load regardless of enable, then sel=00 wrap through FF -> 00
      add(0, 2'b00, 1, 8'hFE, 1, 8'hFE, 0, 0);
      add(1, 2'b00, 0, 8'h00, 1, 8'hFF, 1, 0);
      add(1, 2'b00, 0, 8'h00, 1, 8'h00, 1, 1);
      add(1, 2'b00, 0, 8'h00, 1, 8'h01, 1, 0);
      add(0, 2'b00, 0, 8'h00, 1, 8'h01, 0, 0);
      // sel=01: change cycle holds, then a step every 4 edges
      add(1, 2'b01, 0, 8'h00, 1, 8'h01, 0, 0);
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 3; j++) add(1, 2'b01, 0, 8'h00, 1, 8'(8'h01 + i), 0, 0);
         add(1, 2'b01, 0, 8'h00, 1, 8'(8'h02 + i), 1, 0);
      end
      add(1, 2'b01, 0, 8'h00, 1, 8'h03, 0, 0);
      add(1, 2'b01, 0, 8'h00, 1, 8'h03, 0, 0);
      for (int i = 0; i < 10; i++) add(0, 2'b01, 0, 8'h00, 1, 8'h03, 0, 0);
      add(1, 2'b01, 0, 8'h00, 1, 8'h03, 0, 0);
      add(1, 2'b01, 0, 8'h00, 1, 8'h04, 1, 0);
      // sel 01 -> 11 mid-period
      add(1, 2'b01, 0, 8'h00, 1, 8'h04, 0, 0);
      add(1, 2'b11, 0, 8'h00, 1, 8'h04, 0, 0);
      add(1, 2'b11, 0, 8'h00, 1, 8'h04, 0, 0);
      add(1, 2'b11, 0, 8'h00, 1, 8'h05, 1, 0);
      add(1, 2'b11, 0, 8'h00, 1, 8'h05, 0, 0);
      add(1, 2'b11, 0, 8'h00, 1, 8'h06, 1, 0);
      // back to sel=01, load on the step edge wins
      add(1, 2'b01, 0, 8'h00, 1, 8'h06, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 2'b01, 0, 8'h00, 1, 8'h06, 0, 0);
      add(1, 2'b01, 1, 8'hA5, 1, 8'hA5, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 2'b01, 0, 8'h00, 1, 8'hA5, 0, 0);
      add(1, 2'b01, 0, 8'h00, 1, 8'hA6, 1, 0);
`ifdef RC_UPDOWN_EN
      add(1, 2'b00, 1, 8'h01, 0, 8'h01, 0, 0);
      add(1, 2'b00, 0, 8'h00, 0, 8'h00, 1, 0);
      add(1, 2'b00, 0, 8'h00, 0, 8'hFF, 1, 1);
      add(1, 2'b00, 0, 8'h00, 0, 8'hFE, 1, 0);
      add(1, 2'b00, 0, 8'h00, 1, 8'hFF, 1, 0);
      add(1, 2'b00, 0, 8'h00, 1, 8'h00, 1, 1);
`else
      add(1, 2'b00, 1, 8'h01, 0, 8'h01, 0, 0);
      add(1, 2'b00, 0, 8'h00, 0, 8'h02, 1, 0);
      add(1, 2'b00, 0, 8'h00, 0, 8'h03, 1, 0);
`endif
      add(0, 2'b00, 1, 8'h37, 1, 8'h37, 0, 0);

      #1 check("reset_state", 8'h00, 0, 0);
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      foreach (vecs[i]) begin
         @(negedge clock);
         enable = vecs[i].en;
         sel = vecs[i].sel;
         load = vecs[i].ld;
         load_value = vecs[i].lv;
         up = vecs[i].up;
         @(posedge clock);
         #1 check($sformatf("vec%0d", i), vecs[i].c, vecs[i].t, vecs[i].w);
      end
      // asynchronous reset between edges from count=0x37
      @(negedge clock);
      load = 1'b0;
      #2 resetn = 1'b0;
      #1 check("reset_mid", 8'h00, 0, 0);
      @(negedge clock);
      resetn = 1'b1;
      enable = 1'b1;
      sel = 2'b00;
      up = 1'b1;
      @(posedge clock);
      #1 check("after_reset", 8'h01, 1, 0);
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
